shift_right_seq: RTL

//   Multi-cycle right shifter for MIPS SRL/SRA/SRLV/SRAV; counterpart of the

---
 rtl/shift_right_seq.sv | 82 ++++++++
 1 files changed

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter (logical/arithmetic): shifts at most STEP bits
// per cycle and reports completion with a one-cycle done pulse.
module shift_right_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               arith,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   in,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // STEP may equal WIDTH, so it needs one bit more than a shift amount.
  localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W+1)'(STEP);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc, acc_shr;
  logic [SHAMT_W-1:0] rem, rem_nxt;
  logic               fill;
  logic [SHAMT_W:0]   rem_x, k;
  logic [2*WIDTH-1:0] ext;

  always_comb begin
    rem_x   = {1'b0, rem};
    k       = (rem_x < STEP_C) ? rem_x : STEP_C;
    rem_nxt = rem - k[SHAMT_W-1:0];
    // Shifting the fill word in from above replicates the captured sign.
    ext     = {{WIDTH{fill}}, acc} >> k;
    acc_shr = ext[WIDTH-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (rem_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT) || (state == DONE);
  assign done  = (state == DONE);

  // out is loaded on entry to DONE so it is already valid during the pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      fill  <= 1'b0;
      out   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          acc  <= in;
          rem  <= shamt;
          fill <= arith & in[WIDTH-1];
          if (shamt == '0) out <= in;
        end
        SHIFT: begin
          acc <= acc_shr;
          rem <= rem_nxt;
          if (rem_nxt == '0) out <= acc_shr;
        end
        default: ;
      endcase
    end
  end

endmodule
